// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: one registered shift level per count bit.
// Define SHIFTER_PIPE_ZFLAG_EN to add the registered out_zero flag.
module shifter_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef SHIFTER_PIPE_ZFLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam int L = CNT_W - 1;

  logic [CNT_W-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [CNT_W];
  logic [TAG_W-1:0] tag_q [CNT_W];
  logic [1:0]       op_q  [L];
  logic [CNT_W-1:0] cnt_q [L];

  logic [CNT_W-1:0] adv;
  logic [CNT_W-1:0] src_v;
  logic [WIDTH-1:0] src_d [CNT_W];
  logic [WIDTH-1:0] nxt_d [CNT_W];
  logic [TAG_W-1:0] src_t [CNT_W];
  logic [1:0]       src_op [CNT_W];
  logic [CNT_W-1:0] src_c [CNT_W];

  function automatic logic [WIDTH-1:0] shl(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input int               a
  );
    logic [WIDTH-1:0] r;
    r = d;
    if (a != 0) begin
      unique case (op)
        2'b00:   r = (d << a) | (d >> (WIDTH - a));
        2'b01:   r = d << a;
        2'b10:   r = $signed(d) >>> a;
        default: r = d >> a;
      endcase
    end
    return r;
  endfunction

  // A stage may load when empty or when its successor moves on.
  always_comb begin
    logic a;
    adv = '0;
    a = out_ready;
    for (int k = L; k >= 0; k--) begin
      a = !vld_q[k] || a;
      adv[k] = a;
    end
  end

  assign in_ready = adv[0];

  always_comb begin
    src_v[0]  = in_valid;
    src_d[0]  = in_data;
    src_t[0]  = in_tag;
    src_op[0] = in_op;
    src_c[0]  = in_cnt;
    for (int k = 1; k < CNT_W; k++) begin
      src_v[k]  = vld_q[k-1];
      src_d[k]  = dat_q[k-1];
      src_t[k]  = tag_q[k-1];
      src_op[k] = op_q[k-1];
      src_c[k]  = cnt_q[k-1];
    end
    for (int k = 0; k < CNT_W; k++) begin
      nxt_d[k] = shl(src_d[k], src_op[k],
                     src_c[k][k] ? (1 << k) : 0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < CNT_W; k++) begin
        dat_q[k] <= '0;
        tag_q[k] <= '0;
      end
      for (int k = 0; k < L; k++) begin
        op_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      for (int k = 0; k < CNT_W; k++) begin
        if (adv[k]) begin
          vld_q[k] <= src_v[k];
          if (src_v[k]) begin
            dat_q[k] <= nxt_d[k];
            tag_q[k] <= src_t[k];
          end
        end
      end
      for (int k = 0; k < L; k++) begin
        if (adv[k] && src_v[k]) begin
          op_q[k]  <= src_op[k];
          cnt_q[k] <= src_c[k];
        end
      end
    end
  end

`ifdef SHIFTER_PIPE_ZFLAG_EN
  logic zf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf_q <= 1'b0;
    end else if (!flush && adv[L] && src_v[L]) begin
      zf_q <= (nxt_d[L] == '0);
    end
  end

  assign out_zero = zf_q;
`endif

  assign out_valid = vld_q[L];
  assign out_data  = dat_q[L];
  assign out_tag   = tag_q[L];

endmodule

// File: tb/tb_shifter_pipe.sv
// Bench for shifter_pipe: queue scoreboard with a plain-arithmetic
// shift model, plus directed literal cases.
module tb_shifter_pipe;

  localparam int W  = 16;
  localparam int TW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [CW-1:0] in_cnt = '0;
  logic [1:0]    in_op = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
`ifdef SHIFTER_PIPE_ZFLAG_EN
  logic          out_zero;
`endif

  shifter_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_cnt(in_cnt),
    .in_op(in_op),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_tag(out_tag)
`ifdef SHIFTER_PIPE_ZFLAG_EN
    ,
    .out_zero(out_zero)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
  } beat_t;

  beat_t sb[$];

  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_data = '0;
  logic [TW-1:0] prev_tag = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(
    input logic [W-1:0] d,
    input logic [1:0]   op,
    input int           c
  );
    logic [2*W-1:0] dd;
    dd = {d, d} << c;
    case (op)
      2'd0:    return dd[2*W-1:W];
      2'd1:    return d << c;
      2'd2:    return $signed(d) >>> c;
      default: return d >> c;
    endcase
  endfunction

  // Scoreboard: transfers happen on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_tag", out_tag, prev_tag);
      end
`ifdef SHIFTER_PIPE_ZFLAG_EN
      if (out_valid)
        chk("zflag", out_zero, out_data == '0);
`endif
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", out_valid, 0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_tag", out_tag, e.t);
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        beat_t b;
        b.d = ref_shift(in_data, in_op, int'(in_cnt));
        b.t = in_tag;
        sb.push_back(b);
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_data = out_data;
      prev_tag = out_tag;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic dir(input string nm,
                     input logic [W-1:0] d,
                     input logic [1:0] op,
                     input logic [CW-1:0] c,
                     input logic [TW-1:0] tg,
                     input logic [W-1:0] exp);
    int n;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = d;
    in_op = op;
    in_cnt = c;
    in_tag = tg;
    #1;
    chk({nm, "_rdy"}, in_ready, 1);
    cyc();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
    chk({nm, "_lat"}, n, 4);
    chk({nm, "_data"}, out_data, exp);
    chk({nm, "_tag"}, out_tag, tg);
`ifdef SHIFTER_PIPE_ZFLAG_EN
    chk({nm, "_zero"}, out_zero, exp == '0);
`endif
    cyc();
  endtask

  task automatic drain(input string nm);
    int n;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      cyc();
      n++;
    end
    chk({nm, "_drain"}, sb.size(), 0);
    cyc();
    cyc();
    chk({nm, "_empty"}, out_valid, 0);
  endtask

  logic [W-1:0]  bd [8];
  logic [1:0]    bo [8];
  logic [CW-1:0] bc [8];
  logic [9:0]    hist;
  int            nacc;
  int            nout;

  task automatic offer(input logic v, input int c);
    in_valid = v && (nacc < 8);
    in_data = bd[nacc % 8];
    in_op = bo[nacc % 8];
    in_cnt = bc[nacc % 8];
    in_tag = TW'(nacc);
    #1;
    if (c < 10) hist[c] = in_ready;
    if (in_valid && in_ready) nacc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    cyc();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_tag", out_tag, 0);
    rst = 1'b0;
    cyc();
    chk("rst_ready", in_ready, 1);

    dir("rol", 16'h8001, 2'd0, 4'd1, 4'd3, 16'h0003);
    dir("sra", 16'h8000, 2'd2, 4'd15, 4'd9, 16'hFFFF);
    dir("srl", 16'hF000, 2'd3, 4'd12, 4'd5, 16'h000F);
    dir("sll", 16'h00FF, 2'd1, 4'd4, 4'd12, 16'h0FF0);
    dir("cnt0", 16'h1234, 2'd3, 4'd0, 4'd1, 16'h1234);
    dir("rolw", 16'h0001, 2'd0, 4'd15, 4'd2, 16'h8000);
    dir("sra0", 16'h7FF0, 2'd2, 4'd4, 4'd4, 16'h07FF);
`ifdef SHIFTER_PIPE_ZFLAG_EN
    dir("zf", 16'h8000, 2'd1, 4'd1, 4'd6, 16'h0000);
`endif

    for (int i = 0; i < 8; i++) begin
      bd[i] = W'($urandom);
      bo[i] = 2'($urandom);
      bc[i] = CW'($urandom);
    end

    out_ready = 1'b0;
    nacc = 0;
    hist = '0;
    for (int c = 0; c < 10; c++) offer(1'b1, c);
    chk("burst_hist", hist, 10'b0000001111);
    chk("burst_fill", nacc, 4);
    chk("burst_hold_valid", out_valid, 1);
    chk("burst_hold_tag", out_tag, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && nacc < 8; c++) offer(1'b1, 99);
    chk("burst_all", nacc, 8);
    drain("burst");

    out_ready = 1'b0;
    nacc = 0;
    hist = '0;
    for (int c = 0; c < 10; c++) offer(c != 1, c);
    chk("bubble_hist", hist, 10'b0000011111);
    chk("bubble_fill", nacc, 4);
    chk("bubble_head", out_tag, 0);
    drain("bubble");

    out_ready = 1'b1;
    nacc = 0;
    for (int c = 0; c < 3; c++) offer(1'b1, 99);
    flush = 1'b1;
    offer(1'b1, 99);
    flush = 1'b0;
    in_valid = 1'b0;
    nout = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) nout++;
      cyc();
    end
    chk("flush_none", nout, 0);
    dir("post_flush", 16'h0F0F, 2'd0, 4'd4, 4'd7, 16'hF0F0);

    out_ready = 1'b0;
    nacc = 0;
    for (int c = 0; c < 2; c++) offer(1'b1, 99);
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("pre_rst_valid", out_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_tag", out_tag, 0);
    #10;
    rst = 1'b0;
    out_ready = 1'b1;
    cyc();
    nout = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) nout++;
      cyc();
    end
    chk("arst_stale", nout, 0);
    chk("arst_ready", in_ready, 1);

    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom % 10) < 7;
      out_ready = ($urandom % 10) < 7;
      flush = ($urandom % 60) == 0;
      in_data = W'($urandom);
      in_op = 2'($urandom);
      in_cnt = CW'($urandom);
      in_tag = TW'($urandom);
      cyc();
    end
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
